// File: rtl/ba201_mem_arbiter_pkg.sv
// Shared constants for the ba201 memory arbiter: FSM encodings, memory access types,
// requester identifiers and the watchdog timer sizing helper.
package ba201_mem_arbiter_pkg;

    localparam int ARB_ST_WIDTH = 2;

    localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_IDLE  = 2'd0;
    localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_ISSUE = 2'd1;
    localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_WAIT  = 2'd2;
    localparam logic [ARB_ST_WIDTH-1:0] ARB_ST_DRAIN = 2'd3;

    localparam logic MEM_TYPE_RD = 1'b0;
    localparam logic MEM_TYPE_WR = 1'b1;

    localparam int MEM_MSK_WIDTH = 4;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_src_e;

    // The timer only ever needs to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ba201_arb_rr2.sv
// Two-way round-robin pick: a lone valid requester wins; on a conflict the
// requester that did not win last time is granted. Purely combinational.
module ba201_arb_rr2 (
    input  logic i_valid,
    input  logic d_valid,
    input  logic last_grant,
    output logic i_grant,
    output logic d_grant
);

    logic [1:0] valid;
    logic [1:0] grant;

    assign valid = {d_valid, i_valid};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pick
            assign grant[gi] = valid[gi] & (~valid[1-gi] | (last_grant != 1'(gi)));
        end
    endgenerate

    assign i_grant = grant[0];
    assign d_grant = grant[1];

endmodule

// File: rtl/ba201_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// in flight, with a response watchdog. Optional counters under `ARB_PERF_CNT_EN`.
module ba201_mem_arbiter
    import ba201_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MSK_WIDTH  = MEM_MSK_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  io_i_req_valid,
    output logic                  io_i_req_ready,
    input  logic [ADDR_WIDTH-1:0] io_i_addr,
    output logic                  io_i_resp_valid,
    output logic [DATA_WIDTH-1:0] io_i_rdata,

    input  logic                  io_d_req_valid,
    output logic                  io_d_req_ready,
    input  logic [ADDR_WIDTH-1:0] io_d_addr,
    input  logic                  io_d_type,
    input  logic [DATA_WIDTH-1:0] io_d_wdata,
    input  logic [MSK_WIDTH-1:0]  io_d_wmask,
    output logic                  io_d_resp_valid,
    output logic [DATA_WIDTH-1:0] io_d_rdata,

    output logic                  io_resp_err,

    output logic                  io_mem_req_valid,
    input  logic                  io_mem_req_ready,
    output logic [ADDR_WIDTH-1:0] io_mem_addr,
    output logic                  io_mem_type,
    output logic [DATA_WIDTH-1:0] io_mem_wdata,
    output logic [MSK_WIDTH-1:0]  io_mem_wmask,
    input  logic                  io_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] io_mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           io_perf_i_grants,
    output logic [31:0]           io_perf_d_grants,
    output logic [31:0]           io_perf_conflicts
`endif
);

    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [ARB_ST_WIDTH-1:0] state_reg, state_next;
    req_src_e                last_grant_reg;

    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic                    type_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [MSK_WIDTH-1:0]    wmask_reg;

    logic [TW-1:0]           timer_reg;

    logic                    i_resp_reg, d_resp_reg, err_reg;
    logic [DATA_WIDTH-1:0]   i_rdata_reg, d_rdata_reg;

    logic                    i_grant, d_grant;
    logic                    grant_any;
    logic                    timeout_hit;

    ba201_arb_rr2 u_rr2 (
        .i_valid    (io_i_req_valid),
        .d_valid    (io_d_req_valid),
        .last_grant (last_grant_reg),
        .i_grant    (i_grant),
        .d_grant    (d_grant)
    );

    // Ready is combinational so a grant lands in the same cycle the request appears;
    // it is held low while reset is asserted.
    assign io_i_req_ready = (state_reg == ARB_ST_IDLE) & i_grant & ~rst;
    assign io_d_req_ready = (state_reg == ARB_ST_IDLE) & d_grant & ~rst;
    assign grant_any      = io_i_req_ready | io_d_req_ready;

    assign timeout_hit = (TIMEOUT != 0) && (timer_reg == TIMER_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_ST_IDLE:  if (grant_any)          state_next = ARB_ST_ISSUE;
            ARB_ST_ISSUE: if (io_mem_req_ready)   state_next = ARB_ST_WAIT;
            ARB_ST_WAIT: begin
                if (io_mem_resp_valid)            state_next = ARB_ST_IDLE;
                else if (timeout_hit)             state_next = ARB_ST_DRAIN;
            end
            ARB_ST_DRAIN: if (io_mem_resp_valid)  state_next = ARB_ST_IDLE;
            default:                              state_next = ARB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fetches are always reads with no write payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= REQ_I;
            addr_reg       <= '0;
            type_reg       <= MEM_TYPE_RD;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
        end else if (io_d_req_ready) begin
            last_grant_reg <= REQ_D;
            addr_reg       <= io_d_addr;
            type_reg       <= io_d_type;
            wdata_reg      <= io_d_wdata;
            wmask_reg      <= io_d_wmask;
        end else if (io_i_req_ready) begin
            last_grant_reg <= REQ_I;
            addr_reg       <= io_i_addr;
            type_reg       <= MEM_TYPE_RD;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
        end else if (state_reg == ARB_ST_ISSUE) begin
            timer_reg <= '0;
        end else if ((state_reg == ARB_ST_WAIT) && (TIMEOUT != 0)) begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_resp_reg  <= 1'b0;
            d_resp_reg  <= 1'b0;
            err_reg     <= 1'b0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            i_resp_reg <= 1'b0;
            d_resp_reg <= 1'b0;
            err_reg    <= 1'b0;
            if (state_reg == ARB_ST_WAIT) begin
                if (io_mem_resp_valid) begin
                    if (last_grant_reg == REQ_D) begin
                        d_resp_reg  <= 1'b1;
                        d_rdata_reg <= (type_reg == MEM_TYPE_WR) ? '0 : io_mem_rdata;
                    end else begin
                        i_resp_reg  <= 1'b1;
                        i_rdata_reg <= io_mem_rdata;
                    end
                end else if (timeout_hit) begin
                    err_reg <= 1'b1;
                    if (last_grant_reg == REQ_D) begin
                        d_resp_reg  <= 1'b1;
                        d_rdata_reg <= '0;
                    end else begin
                        i_resp_reg  <= 1'b1;
                        i_rdata_reg <= '0;
                    end
                end
            end
        end
    end

    assign io_mem_req_valid = (state_reg == ARB_ST_ISSUE);
    assign io_mem_addr      = addr_reg;
    assign io_mem_type      = type_reg;
    assign io_mem_wdata     = wdata_reg;
    assign io_mem_wmask     = wmask_reg;

    assign io_i_resp_valid  = i_resp_reg;
    assign io_i_rdata       = i_rdata_reg;
    assign io_d_resp_valid  = d_resp_reg;
    assign io_d_rdata       = d_rdata_reg;
    assign io_resp_err      = err_reg;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_i_reg, perf_d_reg, perf_conf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_reg    <= '0;
            perf_d_reg    <= '0;
            perf_conf_reg <= '0;
        end else begin
            if (io_i_req_ready) perf_i_reg <= perf_i_reg + 32'd1;
            if (io_d_req_ready) perf_d_reg <= perf_d_reg + 32'd1;
            if ((state_reg == ARB_ST_IDLE) && io_i_req_valid && io_d_req_valid)
                perf_conf_reg <= perf_conf_reg + 32'd1;
        end
    end

    assign io_perf_i_grants  = perf_i_reg;
    assign io_perf_d_grants  = perf_d_reg;
    assign io_perf_conflicts = perf_conf_reg;
`endif

endmodule

// File: tb/tb_ba201_mem_arbiter.sv
// Directed bench for ba201_mem_arbiter: stimulus pushes expected responses into a
// scoreboard queue, an independent monitor pops and compares on every response pulse.
module tb_ba201_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        io_i_req_valid, io_i_req_ready, io_i_resp_valid;
    logic [31:0] io_i_addr, io_i_rdata;
    logic        io_d_req_valid, io_d_req_ready, io_d_type, io_d_resp_valid;
    logic [31:0] io_d_addr, io_d_wdata, io_d_rdata;
    logic [3:0]  io_d_wmask;
    logic        io_resp_err;
    logic        io_mem_req_valid, io_mem_req_ready, io_mem_type, io_mem_resp_valid;
    logic [31:0] io_mem_addr, io_mem_wdata, io_mem_rdata;
    logic [3:0]  io_mem_wmask;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] io_perf_i_grants, io_perf_d_grants, io_perf_conflicts;
`endif

    ba201_mem_arbiter #(.TIMEOUT(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .io_i_req_valid    (io_i_req_valid),
        .io_i_req_ready    (io_i_req_ready),
        .io_i_addr         (io_i_addr),
        .io_i_resp_valid   (io_i_resp_valid),
        .io_i_rdata        (io_i_rdata),
        .io_d_req_valid    (io_d_req_valid),
        .io_d_req_ready    (io_d_req_ready),
        .io_d_addr         (io_d_addr),
        .io_d_type         (io_d_type),
        .io_d_wdata        (io_d_wdata),
        .io_d_wmask        (io_d_wmask),
        .io_d_resp_valid   (io_d_resp_valid),
        .io_d_rdata        (io_d_rdata),
        .io_resp_err       (io_resp_err),
        .io_mem_req_valid  (io_mem_req_valid),
        .io_mem_req_ready  (io_mem_req_ready),
        .io_mem_addr       (io_mem_addr),
        .io_mem_type       (io_mem_type),
        .io_mem_wdata      (io_mem_wdata),
        .io_mem_wmask      (io_mem_wmask),
        .io_mem_resp_valid (io_mem_resp_valid),
        .io_mem_rdata      (io_mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .io_perf_i_grants  (io_perf_i_grants),
        .io_perf_d_grants  (io_perf_d_grants),
        .io_perf_conflicts (io_perf_conflicts)
`endif
    );

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [31:0] data, input logic err);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // Present a request in an IDLE cycle, expect the same-cycle grant, then withdraw it
    // and scramble the fields so the latched copy is what reaches memory.
    task automatic issue_req(input logic is_d, input logic [31:0] addr, input logic wr,
                             input logic [31:0] wdata, input logic [3:0] wmask);
        @(negedge clk);
        if (is_d) begin
            io_d_req_valid = 1'b1;
            io_d_addr      = addr;
            io_d_type      = wr;
            io_d_wdata     = wdata;
            io_d_wmask     = wmask;
        end else begin
            io_i_req_valid = 1'b1;
            io_i_addr      = addr;
        end
        #1;
        chk("req_ready", 32'({io_d_req_ready, io_i_req_ready}), is_d ? 32'd2 : 32'd1);
        @(negedge clk);
        io_i_req_valid = 1'b0;
        io_d_req_valid = 1'b0;
        io_i_addr      = 32'hFFFF_FFFF;
        io_d_addr      = 32'hFFFF_FFFF;
        io_d_type      = ~wr;
        io_d_wdata     = 32'hFFFF_FFFF;
        io_d_wmask     = 4'hF;
        #1;
    endtask

    // Called in the ISSUE cycle: checks the downstream request, stalls, accepts, and
    // answers in WAIT cycle 'lat'. Returns in the cycle the requester response is visible.
    task automatic mem_serve(input int stall, input int lat, input logic [31:0] mdata,
                             input logic [31:0] exp_addr, input logic exp_wr,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_wmask,
                             input logic exp_d);
        chk("mem_req_valid", 32'(io_mem_req_valid), 32'd1);
        chk("mem_addr", io_mem_addr, exp_addr);
        chk("mem_type", 32'(io_mem_type), 32'(exp_wr));
        chk("mem_wdata", io_mem_wdata, exp_wdata);
        chk("mem_wmask", 32'(io_mem_wmask), 32'(exp_wmask));
        for (int k = 0; k < stall; k++) begin
            io_mem_req_ready = 1'b0;
            @(negedge clk);
            #1;
            chk("stall_valid", 32'(io_mem_req_valid), 32'd1);
            chk("stall_addr", io_mem_addr, exp_addr);
            chk("stall_wdata", io_mem_wdata, exp_wdata);
            chk("stall_no_ready", 32'({io_d_req_ready, io_i_req_ready}), 32'd0);
        end
        io_mem_req_ready = 1'b1;
        @(negedge clk);
        io_mem_req_ready = 1'b0;
        #1;
        chk("wait_valid_low", 32'(io_mem_req_valid), 32'd0);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            #1;
        end
        io_mem_resp_valid = 1'b1;
        io_mem_rdata      = mdata;
        push_exp(exp_d, (exp_d && exp_wr) ? 32'd0 : mdata, 1'b0);
        @(negedge clk);
        io_mem_resp_valid = 1'b0;
        io_mem_rdata      = 32'hBAD0_BAD0;
        #1;
        chk("resp_latency", 32'(exp_d ? io_d_resp_valid : io_i_resp_valid), 32'd1);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (io_i_req_ready || io_d_req_ready)
                chk("one_ready", 32'(io_i_req_ready & io_d_req_ready), 32'd0);
            if (io_i_resp_valid || io_d_resp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got i=%b d=%b data=0x%08h/0x%08h expected none",
                             io_i_resp_valid, io_d_resp_valid, io_i_rdata, io_d_rdata);
                end else begin
                    e   = sb_q.pop_front();
                    got = e.is_d ? io_d_rdata : io_i_rdata;
                    chk("resp_side", 32'({io_d_resp_valid, io_i_resp_valid}), e.is_d ? 32'd2 : 32'd1);
                    chk("resp_data", got, e.data);
                    chk("resp_err", 32'(io_resp_err), 32'(e.err));
                    $display("resp %s data=0x%08h err=%b", e.is_d ? "d" : "i", got, io_resp_err);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int w;
        rst = 1'b1;
        io_i_req_valid = 1'b1; io_i_addr = 32'h0;
        io_d_req_valid = 1'b0; io_d_addr = 32'h0; io_d_type = 1'b0;
        io_d_wdata = 32'h0; io_d_wmask = 4'h0;
        io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0; io_mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_i_ready", 32'(io_i_req_ready), 32'd0);
        chk("rst_d_ready", 32'(io_d_req_ready), 32'd0);
        chk("rst_mem_valid", 32'(io_mem_req_valid), 32'd0);
        chk("rst_resp", 32'({io_i_resp_valid, io_d_resp_valid, io_resp_err}), 32'd0);
        chk("rst_mem_addr", io_mem_addr, 32'd0);
        chk("rst_i_rdata", io_i_rdata, 32'd0);
        io_i_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Both requesters held valid: grants must alternate D, I, D, I.
        @(negedge clk);
        io_i_req_valid = 1'b1; io_i_addr = 32'h200;
        io_d_req_valid = 1'b1; io_d_addr = 32'h300; io_d_type = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            while (!(io_i_req_ready || io_d_req_ready) && w < 20) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk("conflict_grant", 32'({io_d_req_ready, io_i_req_ready}), (g % 2 == 0) ? 32'd2 : 32'd1);
            $display("grant %0d to %s", g, io_d_req_ready ? "d" : "i");
            @(negedge clk);
            if (g == 3) begin
                io_i_req_valid = 1'b0;
                io_d_req_valid = 1'b0;
            end
            #1;
            mem_serve(0, 1, 32'hA000_0000 + 32'(g), (g % 2 == 0) ? 32'h300 : 32'h200,
                      1'b0, 32'h0, 4'h0, (g % 2 == 0));
        end
`ifdef ARB_PERF_CNT_EN
        chk("perf_i_grants", io_perf_i_grants, 32'd2);
        chk("perf_d_grants", io_perf_d_grants, 32'd2);
        chk("perf_conflicts", io_perf_conflicts, 32'd4);
`endif

        // Lone fetch, memory answers in the second WAIT cycle.
        issue_req(1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
        mem_serve(0, 2, 32'hDEAD_BEEF, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0);

        // Data write: payload forwarded, response data forced to zero.
        issue_req(1'b1, 32'h40, 1'b1, 32'h1234_5678, 4'b0011);
        mem_serve(0, 1, 32'hFFFF_FFFF, 32'h40, 1'b1, 32'h1234_5678, 4'b0011, 1'b1);

        // Downstream stalls five cycles while a fetch waits; fetch is granted afterwards.
        issue_req(1'b1, 32'h80, 1'b0, 32'h0, 4'h0);
        io_i_req_valid = 1'b1;
        io_i_addr      = 32'h700;
        mem_serve(5, 3, 32'h55AA_33CC, 32'h80, 1'b0, 32'h0, 4'h0, 1'b1);
        chk("stall_then_i_grant", 32'(io_i_req_ready), 32'd1);
        @(negedge clk);
        io_i_req_valid = 1'b0;
        #1;
        mem_serve(0, 1, 32'h0F0F_0F0F, 32'h700, 1'b0, 32'h0, 4'h0, 1'b0);

        // Watchdog: no response, error reply after WAIT cycle 8, late response dropped.
        issue_req(1'b0, 32'h500, 1'b0, 32'h0, 4'h0);
        chk("to_mem_valid", 32'(io_mem_req_valid), 32'd1);
        io_mem_req_ready = 1'b1;
        @(negedge clk);
        io_mem_req_ready = 1'b0;
        #1;
        push_exp(1'b0, 32'd0, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            #1;
        end
        chk("no_early_timeout", 32'(io_i_resp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("timeout_resp", 32'(io_i_resp_valid), 32'd1);
        chk("timeout_err", 32'(io_resp_err), 32'd1);
        io_i_req_valid = 1'b1;
        io_i_addr      = 32'h504;
        #1;
        chk("drain_no_grant", 32'(io_i_req_ready), 32'd0);
        @(negedge clk);
        io_mem_resp_valid = 1'b1;
        io_mem_rdata      = 32'hBADB_ADBA;
        #1;
        chk("drain_no_grant2", 32'(io_i_req_ready), 32'd0);
        @(negedge clk);
        io_mem_resp_valid = 1'b0;
        #1;
        chk("stale_dropped", 32'(io_i_resp_valid), 32'd0);
        chk("post_drain_grant", 32'(io_i_req_ready), 32'd1);
        @(negedge clk);
        io_i_req_valid = 1'b0;
        #1;
        mem_serve(0, 1, 32'hCAFE_F00D, 32'h504, 1'b0, 32'h0, 4'h0, 1'b0);

        // Reset while in WAIT: outputs clear at once, nothing is answered.
        issue_req(1'b1, 32'h600, 1'b0, 32'h0, 4'h0);
        chk("rw_mem_valid", 32'(io_mem_req_valid), 32'd1);
        io_mem_req_ready = 1'b1;
        @(negedge clk);
        io_mem_req_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        io_mem_resp_valid = 1'b1; io_mem_rdata = 32'h1111_1111;
        io_i_req_valid = 1'b1; io_i_addr = 32'h610;
        io_d_req_valid = 1'b1; io_d_addr = 32'h608; io_d_type = 1'b0;
        io_d_wdata = 32'h0; io_d_wmask = 4'h0;
        #1;
        chk("arst_mem_valid", 32'(io_mem_req_valid), 32'd0);
        chk("arst_mem_addr", io_mem_addr, 32'd0);
        chk("arst_ready", 32'({io_d_req_ready, io_i_req_ready}), 32'd0);
        chk("arst_d_rdata", io_d_rdata, 32'd0);
        chk("arst_resp", 32'({io_i_resp_valid, io_d_resp_valid, io_resp_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        io_mem_resp_valid = 1'b0;
        #1;
        chk("post_reset_grant", 32'({io_d_req_ready, io_i_req_ready}), 32'd2);
        @(negedge clk);
        io_d_req_valid = 1'b0;
        #1;
        mem_serve(0, 1, 32'h600D_600D, 32'h608, 1'b0, 32'h0, 4'h0, 1'b1);
        chk("post_reset_i_grant", 32'(io_i_req_ready), 32'd1);
        @(negedge clk);
        io_i_req_valid = 1'b0;
        #1;
        mem_serve(0, 2, 32'h1234_ABCD, 32'h610, 1'b0, 32'h0, 4'h0, 1'b0);

        repeat (3) @(negedge clk);
        #3;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
